sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter.sv | 152 +++++++++++++++
 tb/tb_sprite_blitter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
//------------------------------------------------------------------------------
// Module      : sprite_blitter
// Description : Copies an SPR_W x SPR_H 4-bit sprite from a synchronous ROM
//               into a framebuffer, one source pixel per cycle, with optional
//               horizontal mirroring, clipping and a transparent palette index.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module sprite_blitter #(
   parameter int         SPR_W      = 64,
   parameter int         SPR_H      = 64,
   parameter int         FB_W       = 320,
   parameter int         FB_H       = 240,
   parameter logic [3:0] TRANSP_IDX = 4'h0
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               start,
   input  logic signed [10:0] pos_x,
   input  logic signed [10:0] pos_y,
   input  logic               flip_h,
   output logic [11:0]        rom_address,
   input  logic [3:0]         rom_q,
   output logic               fb_we,
   output logic [16:0]        fb_addr,
   output logic [3:0]         fb_data,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [11:0] c_SPR_W  = 12'(SPR_W);
   localparam logic [11:0] c_W_LAST = 12'(SPR_W - 1);
   localparam logic [11:0] c_H_LAST = 12'(SPR_H - 1);
   localparam logic [11:0] c_FB_W   = 12'(FB_W);
   localparam logic [11:0] c_FB_H   = 12'(FB_H);
   localparam logic [16:0] c_FB_W17 = 17'(FB_W);

   logic [1:0]         state_q, state_d;
   logic [11:0]        sx_q, sx_d;
   logic [11:0]        sy_q, sy_d;
   logic signed [10:0] px_q, px_d;
   logic signed [10:0] py_q, py_d;
   logic               flip_q, flip_d;

   // Pixel in flight: destination visibility and address, aligned with rom_q
   logic               vld_q;
   logic [16:0]        addr_q;

   logic               w_issue;
   logic [11:0]        w_src_x;
   logic [11:0]        w_dx;
   logic [11:0]        w_dy;
   logic               w_vis;
   logic [16:0]        w_addr;

   // Sequencer: accept a request in IDLE, walk the sprite in raster order in RUN
   always_comb begin
      state_d = state_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      px_d    = px_q;
      py_d    = py_q;
      flip_d  = flip_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               px_d    = pos_x;
               py_d    = pos_y;
               flip_d  = flip_h;
               sx_d    = '0;
               sy_d    = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (sx_q == c_W_LAST) begin
               sx_d = '0;
               if (sy_q == c_H_LAST) begin
                  state_d = S_DRAIN;
               end else begin
                  sy_d = sy_q + 12'd1;
               end
            end else begin
               sx_d = sx_q + 12'd1;
            end
         end
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Source address and destination coordinate of the pixel issued this cycle
   always_comb begin
      w_issue     = (state_q == S_RUN);
      w_src_x     = flip_q ? (c_W_LAST - sx_q) : sx_q;
      rom_address = w_issue ? (sy_q * c_SPR_W + w_src_x) : 12'd0;
      // Sign-extend the latched origin to 12 bits before adding the offset
      w_dx        = {px_q[10], px_q} + sx_q;
      w_dy        = {py_q[10], py_q} + sy_q;
      w_vis       = !w_dx[11] && (w_dx < c_FB_W) && !w_dy[11] && (w_dy < c_FB_H);
      w_addr      = {5'd0, w_dy} * c_FB_W17 + {5'd0, w_dx};
   end

   // State, counters and latched request registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         sx_q    <= '0;
         sy_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         flip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         px_q    <= px_d;
         py_q    <= py_d;
         flip_q  <= flip_d;
      end
   end

   // One-cycle delay of the destination so it lines up with the ROM data
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         vld_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         vld_q  <= w_issue && w_vis;
         addr_q <= w_addr;
      end
   end

   // Write strobe gated by transparency; vld_q clears asynchronously on Reset
   always_comb begin
      fb_we   = vld_q && (rom_q != TRANSP_IDX);
      fb_addr = fb_we ? addr_q : 17'd0;
      fb_data = fb_we ? rom_q : 4'd0;
      busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
      done    = (state_q == S_DONE);
   end

endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
//------------------------------------------------------------------------------
// Module      : tb_sprite_blitter
// Description : Randomized and directed checks of sprite_blitter against a
//               pixel-list reference model of the blit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sprite_blitter;

   localparam int W    = 64;
   localparam int H    = 64;
   localparam int FBW  = 320;
   localparam int FBH  = 240;
   localparam int NPIX = W * H;
   localparam int LAST = NPIX + 4;

   logic               Clk = 1'b0;
   logic               Reset = 1'b1;
   logic               start = 1'b0;
   logic signed [10:0] pos_x = '0;
   logic signed [10:0] pos_y = '0;
   logic               flip_h = 1'b0;
   logic [11:0]        rom_address;
   logic [3:0]         rom_q = 4'd0;
   logic               fb_we;
   logic [16:0]        fb_addr;
   logic [3:0]         fb_data;
   logic               busy;
   logic               done;

   logic [3:0] rom_mem [0:NPIX-1];
   bit         exp_we  [0:LAST];
   int         exp_addr[0:LAST];
   int         exp_data[0:LAST];

   int n_vec = 0;
   int n_err = 0;

   sprite_blitter #(
      .SPR_W(W), .SPR_H(H), .FB_W(FBW), .FB_H(FBH), .TRANSP_IDX(4'h0)
   ) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
      .flip_h(flip_h), .rom_address(rom_address), .rom_q(rom_q), .fb_we(fb_we),
      .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .done(done)
   );

   always #5 Clk = ~Clk;

   // Synchronous sprite ROM: data one clock after the address
   always @(posedge Clk) rom_q <= rom_mem[rom_address];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected write per cycle after acceptance: pixel k lands in cycle k+2
   task automatic build_model(input int px, input int py, input bit fl);
      for (int c = 0; c <= LAST; c++) begin
         exp_we[c] = 1'b0; exp_addr[c] = 0; exp_data[c] = 0;
      end
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int src, dx, dy;
            logic [3:0] v;
            src = fl ? (W - 1 - x) : x;
            v   = rom_mem[y * W + src];
            dx  = px + x;
            dy  = py + y;
            if (dx >= 0 && dx < FBW && dy >= 0 && dy < FBH && v != 4'h0) begin
               exp_we[y * W + x + 2]   = 1'b1;
               exp_addr[y * W + x + 2] = dy * FBW + dx;
               exp_data[y * W + x + 2] = int'(v);
            end
         end
      end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_we"},   fb_we, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rom"},  rom_address, 0);
      chk({tag, "_addr"}, fb_addr, 0);
      chk({tag, "_data"}, fb_data, 0);
   endtask

   task automatic run_blit(input int px, input int py, input bit fl,
                           input int exp_n, input int rst_at, input bit poke);
      int nw, k, ea;
      nw = 0;
      build_model(px, py, fl);
      @(negedge Clk);
      pos_x = 11'(px); pos_y = 11'(py); flip_h = fl; start = 1'b1;
      for (int c = 1; c <= NPIX + 4; c++) begin
         @(negedge Clk);
         if (c == 1) begin
            start  = 1'b0;
            pos_x  = 11'($urandom);
            pos_y  = 11'($urandom);
            flip_h = ~fl;
         end
         k  = c - 1;
         ea = (c <= NPIX) ? ((k / W) * W + (fl ? (W - 1 - k % W) : (k % W))) : 0;
         chk("busy", busy, (c <= NPIX + 1) ? 1 : 0);
         chk("done", done, (c == NPIX + 2) ? 1 : 0);
         chk("rom_address", rom_address, ea);
         chk("fb_we", fb_we, exp_we[c]);
         if (fb_we) nw++;
         if (exp_we[c]) begin
            chk("fb_addr", fb_addr, exp_addr[c]);
            chk("fb_data", fb_data, exp_data[c]);
         end
         if (poke && c == 100) begin
            start = 1'b1; pos_x = 11'sd7; pos_y = 11'sd9;
         end
         if (poke && c == 101) start = 1'b0;
         if (poke && c == NPIX + 2) begin
            start = 1'b1;
            @(posedge Clk);
            #1 start = 1'b0;
         end
         if (rst_at == c) begin
            Reset = 1'b1;
            #1 check_quiet("rst_now");
            repeat (3) begin
               @(negedge Clk);
               check_quiet("rst_hold");
            end
            Reset = 1'b0;
            repeat (4) begin
               @(negedge Clk);
               check_quiet("rst_after");
            end
            return;
         end
      end
      if (exp_n >= 0) chk("n_writes", nw, exp_n);
   endtask

   initial begin
      for (int i = 0; i < NPIX; i++) rom_mem[i] = 4'd0;
      // Reset state
      repeat (3) @(negedge Clk);
      check_quiet("reset");
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      check_quiet("idle");

      // Fully visible blit, every pixel opaque
      for (int i = 0; i < NPIX; i++) rom_mem[i] = 4'(i) | 4'd1;
      run_blit(0, 0, 1'b0, NPIX, 0, 1'b0);

      // Single opaque pixel at source (1,1)
      for (int i = 0; i < NPIX; i++) rom_mem[i] = 4'd0;
      rom_mem[65] = 4'h7;
      run_blit(10, 20, 1'b0, 1, 0, 1'b0);

      // Mirroring moves source column 0 to destination column 63
      rom_mem[65] = 4'h0;
      rom_mem[0]  = 4'h5;
      run_blit(0, 0, 1'b1, 1, 0, 1'b0);

      // Clipping on left and bottom edges, opaque random content
      for (int i = 0; i < NPIX; i++) rom_mem[i] = 4'($urandom_range(1, 15));
      run_blit(-60, 230, 1'b0, 40, 0, 1'b0);

      // Start pulses while busy and during DONE are ignored
      run_blit(5, 3, 1'b0, -1, 0, 1'b1);

      // Reset mid-blit, then a complete blit afterwards
      run_blit(0, 0, 1'b0, -1, 1000, 1'b0);
      run_blit(0, 0, 1'b0, NPIX, 0, 1'b0);

      // Randomized placement, mirroring and transparency
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NPIX; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         run_blit(int'($urandom_range(0, 420)) - 80, int'($urandom_range(0, 340)) - 80,
                  1'($urandom_range(0, 1)), -1, 0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
